// File: rtl/gbe_tx_pkg.sv
// Shared types and constants for the GbE UDP transmit framer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package gbe_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CSUM,
        ST_HDR,
        ST_DATA,
        ST_PAD,
        ST_GAP
    } state_t;

    localparam int ETH_HDR_LEN = 14;
    localparam int IP_HDR_LEN  = 20;
    localparam int UDP_HDR_LEN = 8;
    localparam int HDR_LEN     = ETH_HDR_LEN + IP_HDR_LEN + UDP_HDR_LEN;  // 42
    localparam int MIN_FRAME   = 60;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
    localparam logic [7:0]  IP_VER_IHL     = 8'h45;
    localparam logic [15:0] IP_FLAGS_DF    = 16'h4000;

    // Header fields in wire order; byte 0 of the frame is the MSB of this struct.
    typedef struct packed {
        logic [47:0] dst_mac;
        logic [47:0] src_mac;
        logic [15:0] ethertype;
        logic [7:0]  ver_ihl;
        logic [7:0]  tos;
        logic [15:0] total_len;
        logic [15:0] ident;
        logic [15:0] flags_frag;
        logic [7:0]  ttl;
        logic [7:0]  proto;
        logic [15:0] hdr_csum;
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [15:0] udp_len;
        logic [15:0] udp_csum;
    } hdr_t;

endpackage

// File: rtl/gbe_tx_ip_csum.sv
// Sequential IPv4 header checksum: 10 accumulate cycles then 2 end-around-carry folds.
// Latency: done pulses in the 12th cycle after start; csum is valid from the following cycle.
// Backpressure: none; operands must stay stable while busy, result held until the next start.
module gbe_tx_ip_csum
    import gbe_tx_pkg::*;
(
    input  logic        mac_clk,
    input  logic        mac_rst_n,
    input  logic        start,
    input  logic [15:0] ip_len,
    input  logic [15:0] ip_id,
    input  logic [7:0]  ttl,
    input  logic [31:0] src_ip,
    input  logic [31:0] dst_ip,
    output logic        done,
    output logic [15:0] csum
);

    logic [19:0] sum;
    logic [3:0]  step;
    logic        busy;
    logic [15:0] word;

    // Header word for the current step, checksum field taken as zero.
    always_comb begin
        word = 16'h0000;
        case (step)
            4'd0:    word = {IP_VER_IHL, 8'h00};
            4'd1:    word = ip_len;
            4'd2:    word = ip_id;
            4'd3:    word = IP_FLAGS_DF;
            4'd4:    word = {ttl, IP_PROTO_UDP};
            4'd5:    word = 16'h0000;
            4'd6:    word = src_ip[31:16];
            4'd7:    word = src_ip[15:0];
            4'd8:    word = dst_ip[31:16];
            4'd9:    word = dst_ip[15:0];
            default: word = 16'h0000;
        endcase
    end

    assign done = busy && (step == 4'd11);
    assign csum = ~sum[15:0];

    // Accumulate ten words, then fold the carry nibble back in twice.
    always_ff @(posedge mac_clk or negedge mac_rst_n) begin
        if (!mac_rst_n) begin
            sum  <= '0;
            step <= '0;
            busy <= 1'b0;
        end else if (start) begin
            sum  <= '0;
            step <= '0;
            busy <= 1'b1;
        end else if (busy) begin
            if (step < 4'd10) begin
                sum <= sum + {4'd0, word};
            end else begin
                sum <= {4'd0, sum[15:0]} + {16'd0, sum[19:16]};
            end
            step <= step + 4'd1;
            if (step == 4'd11) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/gbe_tx_framer.sv
// GbE UDP/IPv4 transmit framer: header + FWFT payload + zero pad to the MAC byte stream (optional GBE_TX_STATS_EN counters).
// Latency: first byte valid 13 cycles after the tx_ack accept cycle; IFG_CYCLES idle cycles after each frame.
// Backpressure: byte held until mac_tx_ack; payload popped only on transfer; empty payload FIFO mid-frame aborts with underrun.
module gbe_tx_framer
    import gbe_tx_pkg::*;
#(
    parameter int          IFG_CYCLES  = 12,
    parameter logic [7:0]  IP_TTL      = 8'h40,
    parameter int          MAX_PAYLOAD = 1472
) (
    input  logic        mac_clk,
    input  logic        mac_rst_n,
    input  logic        local_enable,
    input  logic [47:0] local_mac,
    input  logic [31:0] local_ip,
    input  logic [15:0] local_port,
    input  logic        tx_req,
    output logic        tx_ack,
    input  logic [47:0] tx_dst_mac,
    input  logic [31:0] tx_dst_ip,
    input  logic [15:0] tx_dst_port,
    input  logic [10:0] tx_len,
    input  logic [7:0]  pld_data,
    input  logic        pld_empty,
    output logic        pld_rd,
    output logic [7:0]  mac_tx_data,
    output logic        mac_tx_dvld,
    input  logic        mac_tx_ack,
    output logic        mac_tx_underrun,
    output logic        tx_badreq
`ifdef GBE_TX_STATS_EN
    ,
    output logic [31:0] tx_frame_cnt,
    output logic [15:0] tx_underrun_cnt
`endif
);

    state_t      state, state_d;
    logic        accept;
    logic        len_ok;
    logic        csum_done;
    logic [15:0] csum;

    logic [47:0] dst_mac_q, src_mac_q;
    logic [31:0] dst_ip_q, src_ip_q;
    logic [15:0] dst_port_q, src_port_q;
    logic [10:0] len_q;
    logic [15:0] id_q;
    logic [10:0] byte_cnt;
    logic [10:0] rem_q;
    logic [15:0] gap_cnt;

    logic [15:0] ip_len;
    logic [15:0] udp_len;
    hdr_t        hdr;
    logic [HDR_LEN*8-1:0] hdr_vec;
    logic [5:0]  hdr_rev;
    logic [7:0]  hdr_byte;
    logic        gap_last;

    assign len_ok   = (tx_len != 11'd0) && (tx_len <= 11'(MAX_PAYLOAD));
    assign ip_len   = 16'(IP_HDR_LEN + UDP_HDR_LEN) + {5'd0, len_q};
    assign udp_len  = 16'(UDP_HDR_LEN) + {5'd0, len_q};
    assign gap_last = (gap_cnt == 16'(IFG_CYCLES - 1));

    gbe_tx_ip_csum u_csum (
        .mac_clk   (mac_clk),
        .mac_rst_n (mac_rst_n),
        .start     (accept),
        .ip_len    (ip_len),
        .ip_id     (id_q),
        .ttl       (IP_TTL),
        .src_ip    (src_ip_q),
        .dst_ip    (dst_ip_q),
        .done      (csum_done),
        .csum      (csum)
    );

    // Assemble the 42-byte header from latched request fields.
    always_comb begin
        hdr            = '0;
        hdr.dst_mac    = dst_mac_q;
        hdr.src_mac    = src_mac_q;
        hdr.ethertype  = ETHERTYPE_IPV4;
        hdr.ver_ihl    = IP_VER_IHL;
        hdr.tos        = 8'h00;
        hdr.total_len  = ip_len;
        hdr.ident      = id_q;
        hdr.flags_frag = IP_FLAGS_DF;
        hdr.ttl        = IP_TTL;
        hdr.proto      = IP_PROTO_UDP;
        hdr.hdr_csum   = csum;
        hdr.src_ip     = src_ip_q;
        hdr.dst_ip     = dst_ip_q;
        hdr.src_port   = src_port_q;
        hdr.dst_port   = dst_port_q;
        hdr.udp_len    = udp_len;
        hdr.udp_csum   = 16'h0000;
    end

    assign hdr_vec  = hdr;
    assign hdr_rev  = 6'(HDR_LEN - 1) - byte_cnt[5:0];
    assign hdr_byte = hdr_vec[{hdr_rev, 3'b000} +: 8];

    // State register; reset drops dvld immediately since dvld decodes from state.
    always_ff @(posedge mac_clk or negedge mac_rst_n) begin
        if (!mac_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state and all handshake/stream outputs.
    always_comb begin
        state_d         = state;
        accept          = 1'b0;
        tx_ack          = 1'b0;
        tx_badreq       = 1'b0;
        pld_rd          = 1'b0;
        mac_tx_data     = 8'h00;
        mac_tx_dvld     = 1'b0;
        mac_tx_underrun = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tx_req && local_enable) begin
                    tx_ack = 1'b1;
                    if (len_ok) begin
                        accept  = 1'b1;
                        state_d = ST_CSUM;
                    end else begin
                        tx_badreq = 1'b1;
                    end
                end
            end
            ST_CSUM: begin
                if (csum_done) begin
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                mac_tx_dvld = 1'b1;
                mac_tx_data = hdr_byte;
                if (mac_tx_ack && (byte_cnt == 11'(HDR_LEN - 1))) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                mac_tx_dvld = 1'b1;
                mac_tx_data = pld_data;
                if (mac_tx_ack) begin
                    if (pld_empty) begin
                        mac_tx_underrun = 1'b1;
                        state_d         = ST_GAP;
                    end else begin
                        pld_rd = 1'b1;
                        if (rem_q == 11'd1) begin
                            state_d = (len_q < 11'(MIN_FRAME - HDR_LEN)) ? ST_PAD : ST_GAP;
                        end
                    end
                end
            end
            ST_PAD: begin
                mac_tx_dvld = 1'b1;
                if (mac_tx_ack && (byte_cnt == 11'(MIN_FRAME - 1))) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Latch destination and local identity at accept so the frame is self-consistent.
    always_ff @(posedge mac_clk or negedge mac_rst_n) begin
        if (!mac_rst_n) begin
            dst_mac_q  <= '0;
            src_mac_q  <= '0;
            dst_ip_q   <= '0;
            src_ip_q   <= '0;
            dst_port_q <= '0;
            src_port_q <= '0;
            len_q      <= '0;
        end else if (accept) begin
            dst_mac_q  <= tx_dst_mac;
            src_mac_q  <= local_mac;
            dst_ip_q   <= tx_dst_ip;
            src_ip_q   <= local_ip;
            dst_port_q <= tx_dst_port;
            src_port_q <= local_port;
            len_q      <= tx_len;
        end
    end

    // Frame byte index, remaining payload, gap timer and IP identification.
    always_ff @(posedge mac_clk or negedge mac_rst_n) begin
        if (!mac_rst_n) begin
            byte_cnt <= '0;
            rem_q    <= '0;
            gap_cnt  <= '0;
            id_q     <= '0;
        end else begin
            if (accept) begin
                byte_cnt <= '0;
                rem_q    <= tx_len;
            end else if (mac_tx_dvld && mac_tx_ack && !mac_tx_underrun) begin
                byte_cnt <= byte_cnt + 11'd1;
                if (state == ST_DATA) begin
                    rem_q <= rem_q - 11'd1;
                end
            end
            if (state == ST_GAP) begin
                gap_cnt <= gap_cnt + 16'd1;
                if (gap_last) begin
                    id_q <= id_q + 16'd1;
                end
            end else begin
                gap_cnt <= '0;
            end
        end
    end

`ifdef GBE_TX_STATS_EN
    // Saturating counters: clean frames on gap entry, aborts on each underrun pulse.
    always_ff @(posedge mac_clk or negedge mac_rst_n) begin
        if (!mac_rst_n) begin
            tx_frame_cnt    <= '0;
            tx_underrun_cnt <= '0;
        end else begin
            if ((state_d == ST_GAP) && (state != ST_GAP) && !mac_tx_underrun
                && (tx_frame_cnt != '1)) begin
                tx_frame_cnt <= tx_frame_cnt + 32'd1;
            end
            if (mac_tx_underrun && (tx_underrun_cnt != '1)) begin
                tx_underrun_cnt <= tx_underrun_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gbe_tx_framer.sv
// Directed bench for gbe_tx_framer: header/checksum, padding, full size, request gating, underrun, backpressure, reset.
// Latency: checks 13-cycle accept-to-first-byte and IFG spacing after an abort.
// Backpressure: holds mac_tx_ack low at frame start and verifies byte 0 is held.
module tb_gbe_tx_framer;

    localparam int IFG = 12;
    localparam logic [47:0] SRC_MAC  = 48'h02_00_00_00_00_01;
    localparam logic [47:0] DST_MAC  = 48'h02_00_00_00_00_02;
    localparam logic [31:0] SRC_IP   = 32'h0A_00_00_01;
    localparam logic [31:0] DST_IP   = 32'h0A_00_00_02;
    localparam logic [15:0] SRC_PORT = 16'd1000;
    localparam logic [15:0] DST_PORT = 16'd2000;

    logic        mac_clk, mac_rst_n, local_enable, tx_req, tx_ack;
    logic [47:0] local_mac, tx_dst_mac;
    logic [31:0] local_ip, tx_dst_ip;
    logic [15:0] local_port, tx_dst_port;
    logic [10:0] tx_len;
    logic [7:0]  pld_data, mac_tx_data;
    logic        pld_empty, pld_rd, mac_tx_dvld, mac_tx_ack, mac_tx_underrun, tx_badreq;

    int n_tests = 0, n_fail = 0;
    int pidx = 0, base = 0, avail = 0;
    bit pop_pend = 0;
    logic [7:0] cap[$];
    int fbase = 0, rd0 = 0;
    int cyc = 0, rd_cnt = 0, und_cnt = 0, ack_cnt = 0, dvld_cyc = 0;
    int last_und_cyc = -1000, last_ack_cyc = 0;
    bit und_prev = 0, dvld_after_und = 1;

    gbe_tx_framer dut (
        .mac_clk         (mac_clk),
        .mac_rst_n       (mac_rst_n),
        .local_enable    (local_enable),
        .local_mac       (local_mac),
        .local_ip        (local_ip),
        .local_port      (local_port),
        .tx_req          (tx_req),
        .tx_ack          (tx_ack),
        .tx_dst_mac      (tx_dst_mac),
        .tx_dst_ip       (tx_dst_ip),
        .tx_dst_port     (tx_dst_port),
        .tx_len          (tx_len),
        .pld_data        (pld_data),
        .pld_empty       (pld_empty),
        .pld_rd          (pld_rd),
        .mac_tx_data     (mac_tx_data),
        .mac_tx_dvld     (mac_tx_dvld),
        .mac_tx_ack      (mac_tx_ack),
        .mac_tx_underrun (mac_tx_underrun),
        .tx_badreq       (tx_badreq)
    );

    initial begin
        mac_clk = 1'b0;
        forever #5 mac_clk = ~mac_clk;
    end

    // FWFT payload source: byte at position p is p*7+3.
    assign pld_data  = 8'(pidx * 7 + 3);
    assign pld_empty = (pidx >= avail);

    always @(posedge mac_clk) begin
        if (pop_pend) pidx <= pidx + 1;
    end

    // Mid-cycle monitor: captured bytes and event counters.
    always @(negedge mac_clk) begin
        if (mac_tx_dvld && mac_tx_ack) cap.push_back(mac_tx_data);
        if (pld_rd) rd_cnt = rd_cnt + 1;
        pop_pend = pld_rd;
        if (mac_tx_dvld) dvld_cyc = dvld_cyc + 1;
        if (tx_ack) begin
            ack_cnt = ack_cnt + 1;
            last_ack_cyc = cyc;
        end
        if (und_prev) dvld_after_und = mac_tx_dvld;
        und_prev = mac_tx_underrun;
        if (mac_tx_underrun) begin
            und_cnt = und_cnt + 1;
            last_und_cyc = cyc;
        end
        cyc = cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_csum(input int len, input int id);
        logic [31:0] s;
        s = 32'h4500 + 32'(28 + len) + 32'(id) + 32'h4000 + 32'h4011 + 32'h0000
            + {16'h0, SRC_IP[31:16]} + {16'h0, SRC_IP[15:0]}
            + {16'h0, DST_IP[31:16]} + {16'h0, DST_IP[15:0]};
        while (s[31:16] != 16'h0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        return ~s[15:0];
    endfunction

    function automatic logic [7:0] exp_hdr(input int idx, input int len, input int id);
        logic [335:0] v;
        v = {DST_MAC, SRC_MAC, 16'h0800, 8'h45, 8'h00, 16'(28 + len), 16'(id), 16'h4000,
             8'h40, 8'h11, ref_csum(len, id), SRC_IP, DST_IP, SRC_PORT, DST_PORT,
             16'(8 + len), 16'h0000};
        return v[335 - 8 * idx -: 8];
    endfunction

    task automatic drive_req(input int len);
        @(posedge mac_clk); #1;
        tx_dst_mac  = DST_MAC;
        tx_dst_ip   = DST_IP;
        tx_dst_port = DST_PORT;
        tx_len      = 11'(len);
        tx_req      = 1'b1;
    endtask

    task automatic wait_ack(output bit ok);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge mac_clk);
            if (tx_ack) begin
                ok = 1;
                break;
            end
        end
    endtask

    // Request one frame, optionally hold mac_tx_ack low for the first `hold` byte cycles, wait for its end.
    task automatic run_frame(input int len, input int have, input int hold);
        bit ok, seen, ended;
        int lat, good;
        base  = pidx;
        avail = pidx + have;
        fbase = cap.size();
        rd0   = rd_cnt;
        mac_tx_ack = (hold > 0) ? 1'b0 : 1'b1;
        drive_req(len);
        wait_ack(ok);
        check("ack_seen", 32'(ok), 1);
        check("no_badreq_on_good", 32'(tx_badreq), 0);
        @(posedge mac_clk); #1 tx_req = 1'b0;
        lat = 0;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge mac_clk);
            lat++;
            if (mac_tx_dvld) seen = 1;
        end
        check("first_dvld_latency", 32'(lat), 13);
        if (hold > 0) begin
            good = 0;
            for (int i = 0; i < hold; i++) begin
                if (i > 0) @(negedge mac_clk);
                if (mac_tx_dvld && mac_tx_data == 8'h02) good++;
            end
            check("bp_byte0_held", 32'(good), 32'(hold));
            @(posedge mac_clk); #1 mac_tx_ack = 1'b1;
        end
        ended = 0;
        for (int i = 0; i < 3000 && !ended; i++) begin
            @(negedge mac_clk);
            if (!mac_tx_dvld) ended = 1;
        end
        check("frame_end", 32'(ended), 1);
    endtask

    task automatic check_frame(input int len, input int id);
        int exp_n, bad;
        #1;
        exp_n = (42 + len < 60) ? 60 : 42 + len;
        check("frame_bytes", 32'(cap.size() - fbase), 32'(exp_n));
        check("pld_rd_count", 32'(rd_cnt - rd0), 32'(len));
        if (cap.size() - fbase == exp_n) begin
            for (int i = 0; i < 42; i++)
                check($sformatf("hdr[%0d]", i), 32'(cap[fbase + i]), 32'(exp_hdr(i, len, id)));
            bad = -1;
            for (int i = 0; i < len; i++)
                if (bad < 0 && cap[fbase + 42 + i] != 8'((base + i) * 7 + 3)) bad = i;
            check("payload_first_bad", 32'(bad), 32'hFFFF_FFFF);
            if (exp_n > 42 + len) begin
                bad = -1;
                for (int i = 42 + len; i < 60; i++)
                    if (bad < 0 && cap[fbase + i] != 8'h00) bad = i;
                check("pad_first_bad", 32'(bad), 32'hFFFF_FFFF);
            end
        end
    endtask

    initial begin
        int bad_lens[2];
        int d0, a0, u0, bad;
        bit ok;
        bad_lens[0] = 0;
        bad_lens[1] = 1473;
        mac_rst_n = 1'b0;
        local_enable = 1'b1;
        local_mac = SRC_MAC;
        local_ip = SRC_IP;
        local_port = SRC_PORT;
        tx_req = 1'b0;
        tx_dst_mac = '0;
        tx_dst_ip = '0;
        tx_dst_port = '0;
        tx_len = '0;
        mac_tx_ack = 1'b1;

        // Reset state
        repeat (3) @(negedge mac_clk);
        check("rst_tx_ack", 32'(tx_ack), 0);
        check("rst_badreq", 32'(tx_badreq), 0);
        check("rst_pld_rd", 32'(pld_rd), 0);
        check("rst_dvld", 32'(mac_tx_dvld), 0);
        check("rst_data", 32'(mac_tx_data), 0);
        check("rst_underrun", 32'(mac_tx_underrun), 0);
        @(posedge mac_clk); #1 mac_rst_n = 1'b1;

        // Minimum frame with padding, ID 0
        run_frame(16, 16, 0);
        check_frame(16, 0);
        check("f1_b16", 32'(cap[fbase + 16]), 32'h00);
        check("f1_b17", 32'(cap[fbase + 17]), 32'h2C);
        check("f1_csum_hi", 32'(cap[fbase + 24]), 32'h26);
        check("f1_csum_lo", 32'(cap[fbase + 25]), 32'hBF);
        check("f1_udplen_hi", 32'(cap[fbase + 38]), 32'h00);
        check("f1_udplen_lo", 32'(cap[fbase + 39]), 32'h18);
        check("f1_b58", 32'(cap[fbase + 58]), 32'h00);
        check("f1_b59", 32'(cap[fbase + 59]), 32'h00);

        // Full-size frame, ID 1
        run_frame(1472, 1472, 0);
        check_frame(1472, 1);
        check("f2_id_hi", 32'(cap[fbase + 18]), 32'h00);
        check("f2_id_lo", 32'(cap[fbase + 19]), 32'h01);

        // Illegal lengths: ack and badreq together, no frame
        for (int k = 0; k < 2; k++) begin
            #1 d0 = dvld_cyc;
            drive_req(bad_lens[k]);
            wait_ack(ok);
            check("bad_ack", 32'(ok), 1);
            check("bad_badreq", 32'(tx_badreq), 1);
            @(posedge mac_clk); #1 tx_req = 1'b0;
            repeat (20) @(negedge mac_clk);
            #1 check("bad_no_dvld", 32'(dvld_cyc - d0), 0);
        end

        // local_enable low blocks acceptance
        local_enable = 1'b0;
        #1 a0 = ack_cnt;
        d0 = dvld_cyc;
        drive_req(16);
        repeat (20) @(negedge mac_clk);
        #1 check("disabled_no_ack", 32'(ack_cnt - a0), 0);
        check("disabled_no_dvld", 32'(dvld_cyc - d0), 0);
        tx_req = 1'b0;
        local_enable = 1'b1;

        // Underrun at payload byte 5, ID 2 (unchanged by bad requests)
        u0 = und_cnt;
        run_frame(20, 5, 0);
        #1 check("und_pulses", 32'(und_cnt - u0), 1);
        check("und_dvld_next", 32'(dvld_after_und), 0);
        // 42 header + 5 payload + the aborted byte cycle
        check("und_bytes", 32'(cap.size() - fbase), 48);
        check("und_pld_rd", 32'(rd_cnt - rd0), 5);
        check("und_id_lo", 32'(cap[fbase + 19]), 32'h02);
        bad = -1;
        for (int i = 0; i < 5; i++)
            if (bad < 0 && cap[fbase + 42 + i] != 8'((base + i) * 7 + 3)) bad = i;
        check("und_payload_first_bad", 32'(bad), 32'hFFFF_FFFF);

        // Next request raised during the gap: accepted IFG cycles after the abort, ID 3
        run_frame(16, 16, 0);
        check("ifg_after_underrun", 32'(last_ack_cyc - last_und_cyc), 32'(IFG + 1));
        check_frame(16, 3);

        // Backpressure on byte 0, ID 4
        run_frame(16, 16, 7);
        check_frame(16, 4);

        // Asynchronous reset in the middle of payload
        base = pidx;
        avail = pidx + 100;
        fbase = cap.size();
        drive_req(100);
        wait_ack(ok);
        check("rstmid_ack", 32'(ok), 1);
        @(posedge mac_clk); #1 tx_req = 1'b0;
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge mac_clk);
            if (cap.size() - fbase >= 50) ok = 1;
        end
        check("rstmid_in_data", 32'(ok), 1);
        @(posedge mac_clk); #3 mac_rst_n = 1'b0;
        #1 check("rstmid_dvld_async", 32'(mac_tx_dvld), 0);
        repeat (3) @(negedge mac_clk);
        @(posedge mac_clk); #1 mac_rst_n = 1'b1;
        run_frame(16, 16, 0);
        check_frame(16, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
